cordic_vectoring: RTL and testbench

Iterative CORDIC engine in vectoring mode. Takes a signed Cartesian vector (x, y) and returns its magnitude (with the raw CORDIC gain) and its binary-scaled phase angle. It is the inverse direction of the rotation engine. It has its own internal iteration counter, sequenced by a start/done handshake, and processes one vector per operation.

---
 rtl/cordic_vectoring_if.sv | 24 ++
 rtl/cordic_vectoring.sv | 147 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vectoring_if.sv
// Start/done handshake and result bus for the vectoring-mode CORDIC engine.
interface cordic_vectoring_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
);
  logic             start;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             busy;
  logic             done;
  logic [3:0]       iteration_count;
  logic [WIDTH:0]   mag;
  logic [AW-1:0]    angle;

  modport master (
    output start, x_in, y_in,
    input  busy, done, iteration_count, mag, angle
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, iteration_count, mag, angle
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> gain-scaled magnitude and binary angle.
// One micro-rotation per clock, sequenced IDLE -> PRE -> ITER -> DONE.
module cordic_vectoring #(
  parameter int WIDTH = 16,
  parameter int AW    = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cordic_vectoring_if.slave bus
);

  localparam int XW = WIDTH + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic [AW-1:0] QUARTER = {2'b01, {(AW-2){1'b0}}};

  // atan(2^-i) with a full circle of 2^32, rounded to AW bits below.
  localparam logic [31:0] ATAN32 [16] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
  };
  localparam int RSH = (AW < 32) ? 32 - AW : 0;
  localparam int LSH = (AW > 32) ? AW - 32 : 0;
  localparam logic [63:0] RND = (RSH > 0) ? (64'd1 << (RSH - 1)) : 64'd0;

  function automatic logic [AW-1:0] atan_lut(input logic [3:0] idx);
    return AW'(((64'(ATAN32[idx]) + RND) >> RSH) << LSH);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t                r_state, w_next;
  logic signed [XW-1:0]  r_x, r_y;
  logic        [AW-1:0]  r_z;
  logic        [3:0]     r_i;
  logic        [WIDTH:0] r_mag;
  logic        [AW-1:0]  r_angle;

  logic signed [XW-1:0]  w_px, w_py, w_ix, w_iy, w_xs, w_ys;
  logic        [AW-1:0]  w_pz, w_iz, w_atan;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next              = r_state;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.iteration_count = '0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_PRE;
      S_PRE: begin
        bus.busy = 1'b1;
        w_next   = S_ITER;
      end
      S_ITER: begin
        bus.busy            = 1'b1;
        bus.iteration_count = r_i;
        if (r_i == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Quadrant fold into the right half-plane; operands are already WIDTH+2 wide.
  always_comb begin
    w_px = r_x;
    w_py = r_y;
    w_pz = '0;
    if (r_x[XW-1]) begin
      if (!r_y[XW-1]) begin
        w_px = r_y;
        w_py = -r_x;
        w_pz = QUARTER;
      end else begin
        w_px = -r_y;
        w_py = r_x;
        w_pz = -QUARTER;
      end
    end
  end

  always_comb begin
    w_xs   = r_x >>> r_i;
    w_ys   = r_y >>> r_i;
    w_atan = atan_lut(r_i);
    if (!r_y[XW-1]) begin
      w_ix = r_x + w_ys;
      w_iy = r_y - w_xs;
      w_iz = r_z + w_atan;
    end else begin
      w_ix = r_x - w_ys;
      w_iy = r_y + w_xs;
      w_iz = r_z - w_atan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_mag   <= '0;
      r_angle <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_x <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
          r_y <= {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
          r_z <= '0;
          r_i <= '0;
        end
        S_PRE: begin
          r_x <= w_px;
          r_y <= w_py;
          r_z <= w_pz;
          r_i <= '0;
        end
        S_ITER: begin
          r_x <= w_ix;
          r_y <= w_iy;
          r_z <= w_iz;
          r_i <= r_i + 4'd1;
          if (r_i == LAST) begin
            r_mag   <= w_ix[WIDTH:0];
            r_angle <= w_iz;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mag   = r_mag;
  assign bus.angle = r_angle;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: driver pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_cordic_vectoring;

  localparam int WIDTH = 16;
  localparam int AW    = 16;
  localparam int ITER  = 16;
  localparam int LAT   = ITER + 2;

  logic clk = 1'b0;
  logic rst;

  cordic_vectoring_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  cordic_vectoring #(.WIDTH(WIDTH), .AW(AW), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int ang;
    int xin;
    int yin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   atan_tab [16];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: fold to right half-plane, then ITER shift-add micro-rotations.
  function automatic exp_t model(input int x, input int y);
    longint xx, yy, zz, nx;
    exp_t   e;
    if (x >= 0) begin
      xx = x;  yy = y;  zz = 0;
    end else if (y >= 0) begin
      xx = y;  yy = -x; zz = 2 ** (AW - 2);
    end else begin
      xx = -y; yy = x;  zz = -(2 ** (AW - 2));
    end
    for (int i = 0; i < ITER; i++) begin
      if (yy >= 0) begin
        nx = xx + (yy >>> i);
        yy = yy - (xx >>> i);
        zz = zz + atan_tab[i];
      end else begin
        nx = xx - (yy >>> i);
        yy = yy + (xx >>> i);
        zz = zz - atan_tab[i];
      end
      xx = nx;
    end
    e.mag = int'(xx) & ((1 << (WIDTH + 1)) - 1);
    e.ang = int'(zz) & ((1 << AW) - 1);
    e.xin = x;
    e.yin = y;
    return e;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  // Monitor: every done pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending result");
        end else begin
          e = sb.pop_front();
          check($sformatf("mag(%0d,%0d)", e.xin, e.yin), int'(bus.mag), e.mag);
          check($sformatf("angle(%0d,%0d)", e.xin, e.yin), int'(bus.angle), e.ang);
        end
      end
    end
  end

  // One operation; intrude_k>0 pulses a competing start in cycle k of the run,
  // quick=1 asserts start immediately (caller sits in the cycle after done).
  task automatic run_vec(input int x, input int y, input int intrude_k, input bit quick);
    exp_t e;
    int   lat, busy_cnt;
    bit   got;
    e = model(x, y);
    sb.push_back(e);
    if (!quick) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.x_in  = 16'(x);
    bus.y_in  = 16'(y);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = 16'($urandom);
    bus.y_in  = 16'($urandom);
    got = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= LAT + 10 && !got; k++) begin
      @(negedge clk);
      bus.start = (k == intrude_k);
      if (k == intrude_k) begin
        bus.x_in = 16'(rnd16());
        bus.y_in = 16'(rnd16());
      end
      if (bus.busy === 1'b1) busy_cnt++;
      check($sformatf("iteration_count k=%0d", k), int'(bus.iteration_count),
            (k >= 2 && k <= ITER + 1) ? k - 2 : 0);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    bus.start = 1'b0;
    check($sformatf("latency(%0d,%0d)", x, y), lat, LAT);
    check($sformatf("busy_cycles(%0d,%0d)", x, y), busy_cnt, LAT);
    @(negedge clk);
    check("busy_after_done", int'(bus.busy), 0);
    check("done_pulse_width", int'(bus.done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int d0, found, prev_mag;
    for (int i = 0; i < 16; i++)
      atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** (AW - 1)) / 3.141592653589793 + 0.5);

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_iter", int'(bus.iteration_count), 0);
    check("reset_mag", int'(bus.mag), 0);
    check("reset_angle", int'(bus.angle), 0);
    rst = 1'b0;

    // Axis, diagonal and full-scale vectors.
    run_vec(1000, 0, 0, 1'b0);
    run_vec(0, 1000, 0, 1'b0);
    run_vec(0, -1000, 0, 1'b0);
    run_vec(-1000, 0, 0, 1'b0);
    run_vec(-1000, -1000, 0, 1'b0);
    run_vec(1000, -1000, 0, 1'b0);
    run_vec(-32768, -32768, 0, 1'b0);
    run_vec(-32768, 0, 0, 1'b0);
    run_vec(32767, 32767, 0, 1'b0);
    run_vec(-32768, 32767, 0, 1'b0);

    // Start while busy is ignored; start right after done is accepted.
    d0 = n_done;
    run_vec(1234, -567, 5, 1'b0);
    check("single_done_on_intrude", n_done - d0, 1);
    run_vec(-700, 200, 0, 1'b1);

    // Abort mid-iteration.
    prev_mag = int'(bus.mag);
    check("mag_nonzero_before_abort", int'(prev_mag != 0), 1);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x_in  = 16'(3000);
    bus.y_in  = 16'(-2000);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && int'(bus.iteration_count) == 7) found = 1;
    end
    check("abort_reach_iter7", found, 1);
    rst = 1'b1;
    d0  = n_done;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_iter", int'(bus.iteration_count), 0);
    check("abort_mag", int'(bus.mag), 0);
    check("abort_angle", int'(bus.angle), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_idle", int'(bus.busy), 0);
    run_vec(-2500, 1800, 0, 1'b0);

    // Randomized vectors.
    for (int n = 0; n < 40; n++) begin
      int x, y;
      x = rnd16();
      y = rnd16();
      if (x == 0 && y == 0) x = 1;
      run_vec(x, y, 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
